// File: rtl/display_scan_if.sv
// Requester/display side of the two-digit scan controller: load handshake,
// scan enable and the multiplexed digit outputs.
interface display_scan_if;
    logic       enable;
    logic       load_valid;
    logic [3:0] load_d0;
    logic [3:0] load_d1;
    logic       load_ready;
    logic [1:0] anode_en;
    logic [3:0] sshow;
    logic       frame_done;

    modport master (
        output enable, load_valid, load_d0, load_d1,
        input  load_ready, anode_en, sshow, frame_done
    );

    modport slave (
        input  enable, load_valid, load_d0, load_d1,
        output load_ready, anode_en, sshow, frame_done
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Two-digit multiplexed display scanner with blanking gaps and a frame-atomic
// double-buffered digit load.
//
// state  | meaning
// OFF    | enable low, both digits dark, pending load commits immediately
// SHOW0  | digit 0 lit for ON_CYCLES
// BLANK0 | both dark for BLANK_CYCLES
// SHOW1  | digit 1 lit for ON_CYCLES
// BLANK1 | both dark for BLANK_CYCLES, pending load commits on exit
module display_scan_ctrl #(
    parameter int ON_CYCLES    = 24000,
    parameter int BLANK_CYCLES = 240
) (
    input  logic           clk,
    input  logic           reset,
    display_scan_if.slave  bus
);

    localparam int MAX_DWELL = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CNT_W     = (MAX_DWELL > 1) ? $clog2(MAX_DWELL) : 1;
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    localparam logic [2:0] OFF    = 3'd0;
    localparam logic [2:0] SHOW0  = 3'd1;
    localparam logic [2:0] BLANK0 = 3'd2;
    localparam logic [2:0] SHOW1  = 3'd3;
    localparam logic [2:0] BLANK1 = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             dwell_done;
    logic             alive;
    logic             pending;
    logic [3:0]       pend_d0;
    logic [3:0]       pend_d1;
    logic [3:0]       disp0;
    logic [3:0]       disp1;
    logic             frame_done_q;
    logic             wrap;
    logic             commit;
    logic             accept;

    always_comb begin
        dwell_done = 1'b0;
        if (state == SHOW0 || state == SHOW1)
            dwell_done = (cnt == ON_LAST);
        else if (state == BLANK0 || state == BLANK1)
            dwell_done = (cnt == BLANK_LAST);
    end

    always_comb begin
        state_nxt = state;
        if (!bus.enable) begin
            state_nxt = OFF;
        end else begin
            case (state)
                OFF:     state_nxt = SHOW0;
                SHOW0:   if (dwell_done) state_nxt = BLANK0;
                BLANK0:  if (dwell_done) state_nxt = SHOW1;
                SHOW1:   if (dwell_done) state_nxt = BLANK1;
                BLANK1:  if (dwell_done) state_nxt = SHOW0;
                default: state_nxt = OFF;
            endcase
        end
    end

    // Display registers only ever change at a frame boundary or while dark.
    assign wrap   = (state == BLANK1) && (state_nxt == SHOW0);
    assign commit = pending && ((state == OFF) || wrap);
    assign accept = bus.load_valid && bus.load_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= OFF;
            cnt          <= '0;
            alive        <= 1'b0;
            pending      <= 1'b0;
            pend_d0      <= 4'h0;
            pend_d1      <= 4'h0;
            disp0        <= 4'h0;
            disp1        <= 4'h0;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            alive        <= 1'b1;
            frame_done_q <= wrap;
            if (state_nxt != state || state == OFF)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            // accept needs pending clear and commit needs it set, so they never coincide
            if (commit) begin
                disp0   <= pend_d0;
                disp1   <= pend_d1;
                pending <= 1'b0;
            end else if (accept) begin
                pend_d0 <= bus.load_d0;
                pend_d1 <= bus.load_d1;
                pending <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.anode_en = 2'b00;
        bus.sshow    = 4'h0;
        if (state == SHOW0) begin
            bus.anode_en = 2'b01;
            bus.sshow    = disp0;
        end else if (state == SHOW1) begin
            bus.anode_en = 2'b10;
            bus.sshow    = disp1;
        end
    end

    assign bus.load_ready = alive && !pending;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: a frame-position reference model pushes
// expected outputs to a queue each cycle; they are popped and compared after the edge.
module tb_display_scan_ctrl;

    localparam int ON    = 4;
    localparam int BL    = 2;
    localparam int FRAME = 2 * (ON + BL);

    typedef struct packed {
        logic [1:0] anode;
        logic [3:0] sshow;
        logic       fd;
        logic       ready;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    display_scan_if bus();

    display_scan_ctrl #(.ON_CYCLES(ON), .BLANK_CYCLES(BL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t       exp_q[$];
    logic [7:0] req_q[$];
    int         checks = 0;
    int         errors = 0;
    string      phase  = "init";

    bit         m_on, m_pend, m_started, m_fd;
    int         pos;
    logic [3:0] m_d0, m_d1, m_p0, m_p1;

    task automatic model_clear();
        m_on = 0; m_pend = 0; m_started = 0; m_fd = 0; pos = 0;
        m_d0 = 4'h0; m_d1 = 4'h0; m_p0 = 4'h0; m_p1 = 4'h0;
    endtask

    task automatic model_commit();
        m_d0 = m_p0; m_d1 = m_p1; m_pend = 0;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e       = '0;
        e.fd    = m_fd;
        e.ready = m_started && !m_pend;
        if (m_on) begin
            if (pos < ON) begin
                e.anode = 2'b01;
                e.sshow = m_d0;
            end else if (pos >= ON + BL && pos < 2 * ON + BL) begin
                e.anode = 2'b10;
                e.sshow = m_d1;
            end
        end
        return e;
    endfunction

    task automatic check_out(input string tag);
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        assert (bus.anode_en === e.anode) else begin
            errors++;
            $error("FAIL %s/%s anode_en got %b exp %b", phase, tag, bus.anode_en, e.anode);
        end
        checks++;
        assert (bus.sshow === e.sshow) else begin
            errors++;
            $error("FAIL %s/%s sshow got %h exp %h", phase, tag, bus.sshow, e.sshow);
        end
        checks++;
        assert (bus.frame_done === e.fd) else begin
            errors++;
            $error("FAIL %s/%s frame_done got %b exp %b", phase, tag, bus.frame_done, e.fd);
        end
        checks++;
        assert (bus.load_ready === e.ready) else begin
            errors++;
            $error("FAIL %s/%s load_ready got %b exp %b", phase, tag, bus.load_ready, e.ready);
        end
    endtask

    task automatic drive_req();
        bus.load_valid = (req_q.size() > 0);
        if (req_q.size() > 0) begin
            bus.load_d0 = req_q[0][7:4];
            bus.load_d1 = req_q[0][3:0];
        end
    endtask

    // One clock: advance the model with the inputs currently driven, then compare.
    task automatic step();
        bit acc;
        acc = 0;
        if (reset) begin
            model_clear();
        end else begin
            acc = m_started && !m_pend && bus.load_valid;
            if (!m_on) begin
                if (m_pend) model_commit();
                if (bus.enable) begin
                    m_on = 1;
                    pos  = 0;
                end
                m_fd = 0;
            end else if (!bus.enable) begin
                m_on = 0;
                m_fd = 0;
            end else begin
                pos  = (pos + 1) % FRAME;
                m_fd = (pos == 0);
                if (pos == 0 && m_pend) model_commit();
            end
            if (acc) begin
                m_pend = 1;
                m_p0   = bus.load_d0;
                m_p1   = bus.load_d1;
            end
            m_started = 1;
        end
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        check_out("cycle");
        if (acc) void'(req_q.pop_front());
        drive_req();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_to(input int p);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (m_on && pos == p) break;
            step();
        end
        checks++;
        assert (m_on && pos == p) else begin
            errors++;
            $error("FAIL %s/run_to position got %0d exp %0d", phase, pos, p);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            checks++;
            assert (bus.anode_en !== 2'b11) else begin
                errors++;
                $error("FAIL anode_both got %b exp not 11", bus.anode_en);
            end
        end
    end

    initial begin
        bus.enable     = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_d0    = 4'h0;
        bus.load_d1    = 4'h0;
        reset          = 1'b1;
        model_clear();

        phase = "reset";
        #3;
        exp_q.push_back('0);
        check_out("async");
        step();

        phase = "free_run";
        reset      = 1'b0;
        bus.enable = 1'b1;
        run(30);

        phase = "load_3A";
        run_to(6);
        req_q.push_back(8'h3A);
        drive_req();
        run(26);

        phase = "back_to_back";
        req_q.push_back(8'h56);
        req_q.push_back(8'h78);
        drive_req();
        run(40);

        phase = "off_load";
        run_to(5);
        bus.enable = 1'b0;
        req_q.push_back(8'h91);
        drive_req();
        run(3);
        bus.enable = 1'b1;
        run(15);

        phase = "reset_mid";
        run_to(0);
        req_q.push_back(8'h24);
        drive_req();
        run(2);
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        req_q.delete();
        drive_req();
        exp_q.push_back('0);
        check_out("async");
        step();
        reset = 1'b0;
        run(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
